// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU front end.
// Contents:
//   phase_e      - machine-cycle phase encodings A1..X3 (0..7)
//   OPR_*        - first-nibble opcode constants of the instruction set
//   ALU_*        - operation codes presented to the ALU
package cpu_pkg;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  localparam logic [3:0] OPR_NOP     = 4'h0;
  localparam logic [3:0] OPR_JCN     = 4'h1;
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;
  localparam logic [3:0] OPR_FIN_JIN = 4'h3;
  localparam logic [3:0] OPR_JUN     = 4'h4;
  localparam logic [3:0] OPR_JMS     = 4'h5;
  localparam logic [3:0] OPR_INC     = 4'h6;
  localparam logic [3:0] OPR_ISZ     = 4'h7;
  localparam logic [3:0] OPR_ADD     = 4'h8;
  localparam logic [3:0] OPR_SUB     = 4'h9;
  localparam logic [3:0] OPR_LD      = 4'hA;
  localparam logic [3:0] OPR_XCH     = 4'hB;
  localparam logic [3:0] OPR_BBL     = 4'hC;
  localparam logic [3:0] OPR_LDM     = 4'hD;

  localparam logic [3:0] ALU_NOP = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h8;
  localparam logic [3:0] ALU_SUB = 4'h9;
  localparam logic [3:0] ALU_LDM = 4'hD;

endpackage

// File: rtl/instr_sequencer_decode.sv
// instr_decode: purely combinational instruction decoder.
// Ports:
//   opr, opa    in  first-byte opcode nibble and operand nibble
//   two_byte    out instruction occupies two ROM bytes
//   alu_op      out ALU operation for the execute phases
//   acc_en      out instruction writes the accumulator
//   cy_en       out instruction writes the carry
//   pc_load_en  out instruction loads the PC (JUN/JMS)
//   br_en       out instruction needs a branch evaluation (JCN/ISZ)
module instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opr,
  input  logic [3:0] opa,
  output logic       two_byte,
  output logic [3:0] alu_op,
  output logic       acc_en,
  output logic       cy_en,
  output logic       pc_load_en,
  output logic       br_en
);

  // Only opa[0] matters here (FIM versus SRC).
  logic unused_opa;
  assign unused_opa = ^opa[3:1];

  always_comb begin
    two_byte   = 1'b0;
    alu_op     = ALU_NOP;
    acc_en     = 1'b0;
    cy_en      = 1'b0;
    pc_load_en = 1'b0;
    br_en      = 1'b0;
    case (opr)
      OPR_JCN, OPR_ISZ: begin
        two_byte = 1'b1;
        br_en    = 1'b1;
      end
      OPR_JUN, OPR_JMS: begin
        two_byte   = 1'b1;
        pc_load_en = 1'b1;
      end
      // FIM (even OPA) carries a data byte; SRC (odd OPA) does not.
      OPR_FIM_SRC: two_byte = ~opa[0];
      OPR_ADD: begin
        alu_op = ALU_ADD;
        acc_en = 1'b1;
        cy_en  = 1'b1;
      end
      OPR_SUB: begin
        alu_op = ALU_SUB;
        acc_en = 1'b1;
        cy_en  = 1'b1;
      end
      OPR_LDM: begin
        alu_op = ALU_LDM;
        acc_en = 1'b1;
      end
      OPR_LD, OPR_XCH: acc_en = 1'b1;
      OPR_NOP, OPR_FIN_JIN, OPR_INC, OPR_BBL: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: 8-phase machine-cycle sequencer and instruction decoder
// feeding the ALU.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   run          phase-advance enable; while low every register holds
//   rom_nibble   ROM nibble, captured at the end of M1 and of M2
//   phase, sync  current phase (A1=0..X3=7); sync high in A1
//   second_byte  high for the whole cycle fetching a second byte
//   alu_op, opa_out  ALU operation/operand, valid in X2..X3
//   imm8         second-byte data {hi,lo}
//   acc_we, cy_we, pc_load, br_eval  one-phase strobes in X3
//   pc_inc       one-phase strobe in X1 of every cycle
// Flow control: there is no handshake; run acts as a clock enable, so a
// strobe that is high when run drops stays high and is consumed only on
// the next edge with run=1.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int NIBBLE_W = 4,
  parameter int PHASES   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [NIBBLE_W-1:0]   rom_nibble,
  output logic [2:0]            phase,
  output logic                  sync,
  output logic                  second_byte,
  output logic [NIBBLE_W-1:0]   alu_op,
  output logic [NIBBLE_W-1:0]   opa_out,
  output logic [2*NIBBLE_W-1:0] imm8,
  output logic                  acc_we,
  output logic                  cy_we,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic                  br_eval
);

  phase_e phase_q, phase_d;

  logic [3:0] opr_q, opa_q, imm_hi_q, imm_lo_q;
  logic       pending_q, second_byte_q;
  logic [3:0] alu_op_q, opa_out_q;
  logic       acc_en_q, cy_en_q, pc_load_en_q, br_en_q;
  logic       acc_we_q, cy_we_q, pc_inc_q, pc_load_q, br_eval_q;

  logic       dec_two_byte, dec_acc_en, dec_cy_en, dec_pc_load_en, dec_br_en;
  logic [3:0] dec_alu_op;

  instr_decode u_decode (
    .opr        (opr_q),
    .opa        (opa_q),
    .two_byte   (dec_two_byte),
    .alu_op     (dec_alu_op),
    .acc_en     (dec_acc_en),
    .cy_en      (dec_cy_en),
    .pc_load_en (dec_pc_load_en),
    .br_en      (dec_br_en)
  );

  // Phase register (state) and next-phase logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= PH_A1;
    else     phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    if (run) begin
      if (phase_q == phase_e'(3'(PHASES - 1))) phase_d = PH_A1;
      else                                     phase_d = phase_e'(phase_q + 3'd1);
    end
  end

  // Datapath and strobes, all advancing only on phase-advancing edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opr_q         <= OPR_NOP;
      opa_q         <= 4'h0;
      imm_hi_q      <= 4'h0;
      imm_lo_q      <= 4'h0;
      pending_q     <= 1'b0;
      second_byte_q <= 1'b0;
      alu_op_q      <= ALU_NOP;
      opa_out_q     <= 4'h0;
      acc_en_q      <= 1'b0;
      cy_en_q       <= 1'b0;
      pc_load_en_q  <= 1'b0;
      br_en_q       <= 1'b0;
      acc_we_q      <= 1'b0;
      cy_we_q       <= 1'b0;
      pc_inc_q      <= 1'b0;
      pc_load_q     <= 1'b0;
      br_eval_q     <= 1'b0;
    end else if (run) begin
      case (phase_q)
        PH_M1: begin
          if (second_byte_q) imm_hi_q <= rom_nibble;
          else               opr_q    <= rom_nibble;
        end
        PH_M2: begin
          if (second_byte_q) imm_lo_q <= rom_nibble;
          else               opa_q    <= rom_nibble;
          pc_inc_q <= 1'b1;
        end
        PH_X1: begin
          pc_inc_q <= 1'b0;
          // First byte of a two-byte instruction only arms the next cycle;
          // the retained OPR/OPA are decoded again in the second-byte cycle.
          if (!second_byte_q && dec_two_byte) begin
            pending_q <= 1'b1;
          end else begin
            alu_op_q     <= dec_alu_op;
            opa_out_q    <= opa_q;
            acc_en_q     <= dec_acc_en;
            cy_en_q      <= dec_cy_en;
            pc_load_en_q <= dec_pc_load_en & second_byte_q;
            br_en_q      <= dec_br_en & second_byte_q;
          end
        end
        PH_X2: begin
          acc_we_q  <= acc_en_q;
          cy_we_q   <= cy_en_q;
          pc_load_q <= pc_load_en_q;
          br_eval_q <= br_en_q;
        end
        PH_X3: begin
          alu_op_q      <= ALU_NOP;
          opa_out_q     <= 4'h0;
          acc_en_q      <= 1'b0;
          cy_en_q       <= 1'b0;
          pc_load_en_q  <= 1'b0;
          br_en_q       <= 1'b0;
          acc_we_q      <= 1'b0;
          cy_we_q       <= 1'b0;
          pc_load_q     <= 1'b0;
          br_eval_q     <= 1'b0;
          second_byte_q <= pending_q;
          pending_q     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign phase       = phase_q;
  assign sync        = (phase_q == PH_A1);
  assign second_byte = second_byte_q;
  assign alu_op      = alu_op_q;
  assign opa_out     = opa_out_q;
  assign imm8        = {imm_hi_q, imm_lo_q};
  assign acc_we      = acc_we_q;
  assign cy_we       = cy_we_q;
  assign pc_inc      = pc_inc_q;
  assign pc_load     = pc_load_q;
  assign br_eval     = br_eval_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic [3:0] rom_nibble = 4'h0;
  logic [2:0] phase;
  logic       sync, second_byte, acc_we, cy_we, pc_inc, pc_load, br_eval;
  logic [3:0] alu_op, opa_out;
  logic [7:0] imm8;

  int    n_checks = 0;
  int    n_errors = 0;
  int    acc_writes = 0;
  string test_name = "reset";
  logic [7:0] exp_q[$];

  instr_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .rom_nibble (rom_nibble),
    .phase      (phase),
    .sync       (sync),
    .second_byte(second_byte),
    .alu_op     (alu_op),
    .opa_out    (opa_out),
    .imm8       (imm8),
    .acc_we     (acc_we),
    .cy_we      (cy_we),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .br_eval    (br_eval)
  );

  // Clock / reset-independent monitors
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && run && acc_we) acc_writes++;
  end

  // Checking
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0h, expected %0h", test_name, tag, got, exp);
    end
  endtask

  // Drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input logic [2:0] e_phase);
    check("phase", 8'(phase), 8'(e_phase));
    check("sync", 8'(sync), 8'(e_phase == 3'd0));
    check("alu_op", 8'(alu_op), 8'h00);
    check("opa_out", 8'(opa_out), 8'h00);
    check("acc_we", 8'(acc_we), 8'h00);
    check("cy_we", 8'(cy_we), 8'h00);
    check("pc_load", 8'(pc_load), 8'h00);
    check("br_eval", 8'(br_eval), 8'h00);
  endtask

  // One full machine cycle from A1, presenting n1 in M1 and n2 in M2.
  task automatic run_cycle(input string name, input logic [3:0] n1, input logic [3:0] n2,
                           input logic sb, input logic [3:0] e_alu, input logic [3:0] e_opa,
                           input logic e_acc, input logic e_cy, input logic e_pl,
                           input logic e_br, input logic [7:0] e_imm);
    logic x23, x3;
    test_name = name;
    if (sb) exp_q.push_back(e_imm);
    for (int p = 0; p < 8; p++) begin
      x23 = (p == 6) || (p == 7);
      x3  = (p == 7);
      check("phase", 8'(phase), 8'(p));
      check("sync", 8'(sync), 8'(p == 0));
      check("second_byte", 8'(second_byte), 8'(sb));
      check("pc_inc", 8'(pc_inc), 8'(p == 5));
      check("alu_op", 8'(alu_op), x23 ? 8'(e_alu) : 8'h00);
      if (!sb) check("opa_out", 8'(opa_out), x23 ? 8'(e_opa) : 8'h00);
      check("acc_we", 8'(acc_we), 8'(x3 & e_acc));
      check("cy_we", 8'(cy_we), 8'(x3 & e_cy));
      check("pc_load", 8'(pc_load), 8'(x3 & e_pl));
      check("br_eval", 8'(br_eval), 8'(x3 & e_br));
      if (sb && x23) begin
        check("imm8", imm8, exp_q[0]);
        if (x3) void'(exp_q.pop_front());
      end
      rom_nibble = (p == 3) ? n1 : (p == 4) ? n2 : 4'h0;
      step();
    end
  endtask

  initial begin
    int w0;
    #2;
    rst = 1'b1;
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle(3'd0);
    check("second_byte", 8'(second_byte), 8'h00);
    check("pc_inc", 8'(pc_inc), 8'h00);
    check("imm8", imm8, 8'h00);
    rst = 1'b0;

    //             name    n1    n2    sb  alu   opa   acc cy pl br imm
    run_cycle("add_r3",  4'h8, 4'h3, 0, 4'h8, 4'h3, 1, 1, 0, 0, 8'h00);
    run_cycle("ldm_5",   4'hD, 4'h5, 0, 4'hD, 4'h5, 1, 0, 0, 0, 8'h00);
    run_cycle("jun_b1",  4'h4, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 8'h00);
    run_cycle("jun_b2",  4'h1, 4'h2, 1, 4'h0, 4'h0, 0, 0, 1, 0, 8'h12);
    run_cycle("jcn_b1",  4'h1, 4'h4, 0, 4'h0, 4'h0, 0, 0, 0, 0, 8'h00);
    run_cycle("jcn_b2",  4'h5, 4'h6, 1, 4'h0, 4'h0, 0, 0, 0, 1, 8'h56);
    run_cycle("isz_b1",  4'h7, 4'h2, 0, 4'h0, 4'h0, 0, 0, 0, 0, 8'h00);
    run_cycle("isz_b2",  4'h3, 4'h4, 1, 4'h0, 4'h0, 0, 0, 0, 1, 8'h34);
    run_cycle("fim_b1",  4'h2, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 8'h00);
    run_cycle("fim_b2",  4'h9, 4'h9, 1, 4'h0, 4'h0, 0, 0, 0, 0, 8'h99);
    run_cycle("src",     4'h2, 4'h1, 0, 4'h0, 4'h1, 0, 0, 0, 0, 8'h00);
    run_cycle("after_src", 4'h9, 4'hF, 0, 4'h9, 4'hF, 1, 1, 0, 0, 8'h00);
    run_cycle("ld",      4'hA, 4'h5, 0, 4'h0, 4'h5, 1, 0, 0, 0, 8'h00);
    run_cycle("xch",     4'hB, 4'h2, 0, 4'h0, 4'h2, 1, 0, 0, 0, 8'h00);
    run_cycle("jms_b1",  4'h5, 4'h7, 0, 4'h0, 4'h0, 0, 0, 0, 0, 8'h00);
    run_cycle("jms_b2",  4'hA, 4'hB, 1, 4'h0, 4'h0, 0, 0, 1, 0, 8'hAB);

    // Stall at M2 and at X3 during ADD R6.
    test_name = "stall";
    w0 = acc_writes;
    for (int p = 0; p < 4; p++) begin
      rom_nibble = (p == 3) ? 4'h8 : 4'h0;
      step();
    end
    rom_nibble = 4'h6;
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("m2_hold_phase", 8'(phase), 8'd4);
      check("m2_hold_pc_inc", 8'(pc_inc), 8'h00);
    end
    run = 1'b1;
    step();
    rom_nibble = 4'h0;
    check("x1_phase", 8'(phase), 8'd5);
    check("x1_pc_inc", 8'(pc_inc), 8'h01);
    step();
    check("x2_alu_op", 8'(alu_op), 8'h08);
    check("x2_opa_out", 8'(opa_out), 8'h06);
    step();
    check("x3_acc_we", 8'(acc_we), 8'h01);
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("x3_hold_phase", 8'(phase), 8'd7);
      check("x3_hold_acc_we", 8'(acc_we), 8'h01);
      check("x3_hold_cy_we", 8'(cy_we), 8'h01);
      check("x3_hold_alu_op", 8'(alu_op), 8'h08);
    end
    run = 1'b1;
    step();
    check_idle(3'd0);
    check("acc_writes", 8'(acc_writes - w0), 8'd1);

    // Reset in X1 of a pending JUN second-byte cycle.
    run_cycle("rst_jun_b1", 4'h4, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 8'h00);
    test_name = "rst_mid";
    for (int p = 0; p < 5; p++) begin
      rom_nibble = (p == 3) ? 4'h1 : (p == 4) ? 4'h2 : 4'h0;
      step();
    end
    rom_nibble = 4'h0;
    check("pre_phase", 8'(phase), 8'd5);
    check("pre_second_byte", 8'(second_byte), 8'h01);
    check("pre_pc_inc", 8'(pc_inc), 8'h01);
    rst = 1'b1;
    #1;
    check_idle(3'd0);
    check("second_byte", 8'(second_byte), 8'h00);
    check("pc_inc", 8'(pc_inc), 8'h00);
    check("imm8", imm8, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_cycle("post_rst_add", 4'h8, 4'h1, 0, 4'h8, 4'h1, 1, 1, 0, 0, 8'h00);

    check("exp_q_empty", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
